// File: rtl/b2_mux_3_1_rr_arbiter.sv
// Round-robin arbiter sharing one W-bit 3:1 mux output between three requesters; registered grant, y combinational.
// Latency: req -> gnt/sel/valid one edge; optional quantum preemption built under `define MUX_ARB_TIMEOUT_EN.
module b2_mux_3_1_rr_arbiter #(
    parameter int W       = 2,
    parameter int QUANTUM = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [2:0]   req_i,
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    output logic [2:0]   gnt_o,
    output logic [1:0]   sel_o,
    output logic         valid_o,
    output logic [W-1:0] y_o
);

    if (QUANTUM < 1) begin : g_bad_quantum
        $error("QUANTUM must be >= 1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic       valid_q, valid_d;

    logic [2:0] pick_all;
    logic [2:0] pick_oth;
    logic       owner_req;
    logic       do_grant;
    logic [1:0] nxt_idx;
    logic [W-1:0] mux_dat;

    // Circular search starting after ptr; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] mask);
        logic [2:0] res;
        logic [1:0] cand;
        res  = 3'b000;
        cand = ptr;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!res[2] && mask[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(QUANTUM - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        pick_all  = rr_pick(ptr_q, req_i);
        pick_oth  = rr_pick(ptr_q, req_i & ~gnt_q);
        owner_req = |(req_i & gnt_q);
        do_grant  = 1'b0;
        nxt_idx   = 2'd0;
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;

        case (state_q)
            S_IDLE: begin
                if (pick_all[2]) begin
                    do_grant = 1'b1;
                    nxt_idx  = pick_all[1:0];
                end
            end
            S_GRANT: begin
                // Owner's own bit is already low here, so pick_all never re-selects it.
                if (!owner_req) begin
                    if (pick_all[2]) begin
                        do_grant = 1'b1;
                        nxt_idx  = pick_all[1:0];
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = 3'b000;
                        sel_d   = 2'b11;
                        valid_d = 1'b0;
                    end
                end
`ifdef MUX_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_MAX && pick_oth[2]) begin
                    do_grant = 1'b1;
                    nxt_idx  = pick_oth[1:0];
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
                sel_d   = 2'b11;
                valid_d = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_d = S_GRANT;
            gnt_d   = 3'b001 << nxt_idx;
            sel_d   = nxt_idx;
            ptr_d   = nxt_idx;
            valid_d = 1'b1;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (do_grant || state_d == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`else
    logic unused_pick_oth;
    assign unused_pick_oth = ^pick_oth;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= 2'b11;
            ptr_q   <= 2'd2;
            valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    mux_dat = d0_i;
            2'd1:    mux_dat = d1_i;
            2'd2:    mux_dat = d2_i;
            default: mux_dat = '0;
        endcase
    end

    assign y_o     = valid_q ? mux_dat : '0;
    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_b2_mux_3_1_rr_arbiter.sv
// Directed bench for b2_mux_3_1_rr_arbiter: vector table plus reset, quantum and lone-holder sequences.
module tb_b2_mux_3_1_rr_arbiter;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req;
    logic [W-1:0] d0, d1, d2;
    logic [2:0]   gnt;
    logic [1:0]   sel;
    logic         valid;
    logic [W-1:0] y;

    int n_chk  = 0;
    int n_fail = 0;

    b2_mux_3_1_rr_arbiter #(.W(W), .QUANTUM(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .d0_i    (d0),
        .d1_i    (d1),
        .d2_i    (d2),
        .gnt_o   (gnt),
        .sel_o   (sel),
        .valid_o (valid),
        .y_o     (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [1:0] d0;
        logic [1:0] d1;
        logic [1:0] d2;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       vld;
        logic [1:0] y;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic [2:0] r, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] c, input logic [2:0] g, input logic [1:0] s,
                                input logic v, input logic [1:0] yy);
        vec_t t;
        t.req = r; t.d0 = a; t.d1 = b; t.d2 = c;
        t.gnt = g; t.sel = s; t.vld = v; t.y = yy;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] g, input logic [1:0] s,
                             input logic v, input logic [1:0] yy);
        chk({tag, ".gnt"},   {5'd0, gnt},   {5'd0, g});
        chk({tag, ".sel"},   {6'd0, sel},   {6'd0, s});
        chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
        chk({tag, ".y"},     {6'd0, y},     {6'd0, yy});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_g;

        // Starting from ptr=2: round robin 0,1,2,0, idle, single request, holds and handoffs.
        vecs[0]  = mk(3'b111, 2'b01, 2'b10, 2'b11, 3'b001, 2'b00, 1'b1, 2'b01);
        vecs[1]  = mk(3'b110, 2'b01, 2'b10, 2'b11, 3'b010, 2'b01, 1'b1, 2'b10);
        vecs[2]  = mk(3'b101, 2'b01, 2'b10, 2'b11, 3'b100, 2'b10, 1'b1, 2'b11);
        vecs[3]  = mk(3'b011, 2'b01, 2'b10, 2'b11, 3'b001, 2'b00, 1'b1, 2'b01);
        vecs[4]  = mk(3'b000, 2'b01, 2'b10, 2'b11, 3'b000, 2'b11, 1'b0, 2'b00);
        vecs[5]  = mk(3'b010, 2'b01, 2'b10, 2'b11, 3'b010, 2'b01, 1'b1, 2'b10);
        vecs[6]  = mk(3'b010, 2'b01, 2'b10, 2'b11, 3'b010, 2'b01, 1'b1, 2'b10);
        vecs[7]  = mk(3'b000, 2'b01, 2'b10, 2'b11, 3'b000, 2'b11, 1'b0, 2'b00);
        vecs[8]  = mk(3'b000, 2'b01, 2'b10, 2'b11, 3'b000, 2'b11, 1'b0, 2'b00);
        vecs[9]  = mk(3'b100, 2'b01, 2'b10, 2'b11, 3'b100, 2'b10, 1'b1, 2'b11);
        vecs[10] = mk(3'b101, 2'b01, 2'b10, 2'b11, 3'b100, 2'b10, 1'b1, 2'b11);
        vecs[11] = mk(3'b001, 2'b01, 2'b10, 2'b11, 3'b001, 2'b00, 1'b1, 2'b01);
        vecs[12] = mk(3'b111, 2'b01, 2'b10, 2'b11, 3'b001, 2'b00, 1'b1, 2'b01);
        vecs[13] = mk(3'b110, 2'b01, 2'b10, 2'b11, 3'b010, 2'b01, 1'b1, 2'b10);
        vecs[14] = mk(3'b000, 2'b01, 2'b10, 2'b11, 3'b000, 2'b11, 1'b0, 2'b00);
        vecs[15] = mk(3'b000, 2'b01, 2'b10, 2'b11, 3'b000, 2'b11, 1'b0, 2'b00);
        vecs[16] = mk(3'b001, 2'b10, 2'b10, 2'b11, 3'b001, 2'b00, 1'b1, 2'b10);
        vecs[17] = mk(3'b001, 2'b00, 2'b10, 2'b11, 3'b001, 2'b00, 1'b1, 2'b00);
        vecs[18] = mk(3'b000, 2'b01, 2'b10, 2'b11, 3'b000, 2'b11, 1'b0, 2'b00);

        rst = 1'b1;
        req = 3'b000;
        d0  = 2'b01;
        d1  = 2'b10;
        d2  = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 3'b000, 2'b11, 1'b0, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            req = vecs[i].req;
            d0  = vecs[i].d0;
            d1  = vecs[i].d1;
            d2  = vecs[i].d2;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].vld, vecs[i].y);
        end

        // Reset mid-grant: outputs drop without a clock edge and ptr returns to 2.
        req = 3'b010;
        tick();
        check_out("pre_rst", 3'b010, 2'b01, 1'b1, 2'b10);
        #3;
        rst = 1'b1;
        #1;
        check_out("async_rst", 3'b000, 2'b11, 1'b0, 2'b00);
        #2;
        rst = 1'b0;
        req = 3'b111;
        tick();
        check_out("post_rst", 3'b001, 2'b00, 1'b1, 2'b01);

        // Two requesters held continuously.
        rst = 1'b1;
        req = 3'b011;
        #2;
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
`ifdef MUX_ARB_TIMEOUT_EN
            exp_g = (((k - 1) / 4) % 2 == 1) ? 3'b010 : 3'b001;
`else
            exp_g = 3'b001;
`endif
            chk($sformatf("quantum%0d.gnt", k), {5'd0, gnt}, {5'd0, exp_g});
        end

        // Lone holder is never preempted.
        req = 3'b001;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("lone%0d.gnt", k), {5'd0, gnt}, 8'h01);
            chk($sformatf("lone%0d.valid", k), {7'd0, valid}, 8'h01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
